serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around a single instance of the existing `fa` full-adder cell. Accepts two operands and a carry-in over a valid/ready handshake. Adds them LSB-first, one bit per clock, with the carry held in a flip-flop between bits. Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. This is the sequential stage that drives `fa` and consumes its outputs; it is the low-area alternative to the ripple adder in the arithmetic library.

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/serial_adder_fa.sv | 13 +
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell reused by the serial adder datapath.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fa cell, LSB-first, carry kept in a flop
// between bits, operands in and result out over valid/ready handshakes.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  import serial_adder_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;

  fa u_fa (
    .a_i  (a_sr_q[0]),
    .b_i  (b_sr_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_sr_d  = sum_sr_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sum  = sum_sr_q;
  assign cout = carry_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder with WIDTH=8.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drives one operation and completes the result handshake after gap cycles.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input int gap, output logic [7:0] rs, output logic rc, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL op_timeout: out_valid=%0b required 1 within 40 cycles", out_valid);
    end
    rs = sum; rc = cout;
    repeat (gap) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", sum); end
    if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %0b want 0", cout); end
    $display("reset: in_ready=%0b out_valid=%0b busy=%0b sum=%h cout=%0b", in_ready, out_valid, busy, sum, cout);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int busy_n, lat;
    logic [7:0] s;
    logic c;
    busy_n = 0; lat = -1; s = 8'h00; c = 1'b0;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_n++;
      if (out_valid && lat < 0) begin
        lat = i; s = sum; c = cout;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks += 5;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
    if (s !== 8'h96) begin errors++; $display("FAIL basic_sum: got %h want 96", s); end
    if (c !== 1'b0) begin errors++; $display("FAIL basic_cout: got %0b want 0", c); end
    if (busy_n !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 9", busy_n); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after: got %0b want 1", in_ready); end
    $display("basic: 5A+3C+0 -> sum=%h cout=%0b lat=%0d busy=%0d", s, c, lat, busy_n);
  endtask

  task automatic test_overflow();
    logic [7:0] s;
    logic c;
    int lat;
    run_op(8'hFF, 8'h01, 1'b0, 0, s, c, lat);
    checks += 2;
    if (s !== 8'h00) begin errors++; $display("FAIL ovf1_sum: got %h want 00", s); end
    if (c !== 1'b1) begin errors++; $display("FAIL ovf1_cout: got %0b want 1", c); end
    $display("overflow: FF+01+0 -> sum=%h cout=%0b", s, c);
    run_op(8'hFF, 8'hFF, 1'b1, 1, s, c, lat);
    checks += 2;
    if (s !== 8'hFF) begin errors++; $display("FAIL ovf2_sum: got %h want FF", s); end
    if (c !== 1'b1) begin errors++; $display("FAIL ovf2_cout: got %0b want 1", c); end
    $display("overflow: FF+FF+1 -> sum=%h cout=%0b", s, c);
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    a = 8'h11; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks += 4;
      if (sum !== 8'h46) begin errors++; $display("FAIL bp_sum[%0d]: got %h want 46", i, sum); end
      if (cout !== 1'b0) begin errors++; $display("FAIL bp_cout[%0d]: got %0b want 0", i, cout); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %0b want 1", i, out_valid); end
      @(negedge clk);
    end
    $display("backpressure: held sum=%h cout=%0b for 5 cycles", sum, cout);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after: got %0b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept: busy=%0b want 1", busy); end
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    checks += 2;
    if (sum !== 8'h12) begin errors++; $display("FAIL bp_next_sum: got %h want 12", sum); end
    if (cout !== 1'b0) begin errors++; $display("FAIL bp_next_cout: got %0b want 0", cout); end
    $display("backpressure: queued 11+01+0 -> sum=%h cout=%0b", sum, cout);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_operand_change();
    int n;
    @(negedge clk);
    a = 8'hA5; b = 8'h4B; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      @(negedge clk);
      n++;
    end
    checks += 2;
    if (sum !== 8'hF1) begin errors++; $display("FAIL chg_sum: got %h want F1", sum); end
    if (cout !== 1'b0) begin errors++; $display("FAIL chg_cout: got %0b want 0", cout); end
    $display("operand_change: A5+4B+1 -> sum=%h cout=%0b", sum, cout);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int pulses, lat;
    logic [7:0] s;
    logic c;
    @(negedge clk);
    a = 8'h77; b = 8'h99; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %0b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %0b want 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
    if (sum !== 8'h00) begin errors++; $display("FAIL abort_sum: got %h want 00", sum); end
    if (cout !== 1'b0) begin errors++; $display("FAIL abort_cout: got %0b want 0", cout); end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_no_out_valid: got %0d pulses want 0", pulses); end
    $display("reset_abort: pulses after abort=%0d", pulses);
    run_op(8'h10, 8'h20, 1'b1, 0, s, c, lat);
    checks += 2;
    if (s !== 8'h31) begin errors++; $display("FAIL abort_follow_sum: got %h want 31", s); end
    if (c !== 1'b0) begin errors++; $display("FAIL abort_follow_cout: got %0b want 0", c); end
    $display("reset_abort: 10+20+1 -> sum=%h cout=%0b", s, c);
  endtask

  task automatic test_random();
    logic [7:0] ta, tb_v, s;
    logic tc, c;
    logic [8:0] expv;
    int lat, gap;
    for (int i = 0; i < 1000; i++) begin
      ta = 8'($urandom); tb_v = 8'($urandom); tc = 1'($urandom);
      gap = $urandom_range(0, 3);
      run_op(ta, tb_v, tc, gap, s, c, lat);
      expv = {1'b0, ta} + {1'b0, tb_v} + {8'h00, tc};
      checks += 2;
      if ({c, s} !== expv) begin
        errors++;
        $display("FAIL rand_result[%0d]: %h+%h+%0b got %h want %h", i, ta, tb_v, tc, {c, s}, expv);
      end
      if (lat !== 8) begin
        errors++;
        $display("FAIL rand_latency[%0d]: got %0d want 8", i, lat);
      end
      $display("random[%0d]: %h+%h+%0b -> %h gap=%0d", i, ta, tb_v, tc, {c, s}, gap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_operand_change();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
